// File: rtl/pin_entry_ctrl_if.sv
// Purpose: signal bundle between the unlock-flow controller and its
//          neighbours (encoder/pushbutton front end in, seven_seg and
//          status indicators out).
// Ports:
//   enc            - free-running encoder count, wraps mod 16
//   pb_press_type  - one-cycle press event (0 none, 1 short, 2 long, 3 double)
//   display_value  - hex nibble for seven_seg
//   display_select - digit position for seven_seg
//   digit_idx      - digit currently being edited
//   unlocked / locked_out / err - status flags
//   fail_count     - consecutive failed attempts
interface pin_entry_ctrl_if;
  logic [3:0] enc;
  logic [2:0] pb_press_type;
  logic [3:0] display_value;
  logic [1:0] display_select;
  logic [1:0] digit_idx;
  logic       unlocked;
  logic       locked_out;
  logic       err;
  logic [1:0] fail_count;

  modport master (
    output enc, pb_press_type,
    input  display_value, display_select, digit_idx,
           unlocked, locked_out, err, fail_count
  );

  modport slave (
    input  enc, pb_press_type,
    output display_value, display_select, digit_idx,
           unlocked, locked_out, err, fail_count
  );
endinterface

// File: rtl/pin_entry_ctrl.sv
// Purpose: turns encoder rotation and pushbutton presses into a hex PIN,
//          checks it against PIN_CODE and sequences open / fail / lockout.
// Ports:
//   clk  - system clock
//   rstn - synchronous active-low reset
//   bus  - pin_entry_ctrl_if.slave (encoder/press in, display/status out)
module pin_entry_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter logic [15:0] PIN_CODE    = 16'hC5A7,
  parameter int unsigned MAX_FAIL    = 3,
  parameter logic [23:0] FAIL_HOLD   = 24'd6_000_000,
  parameter logic [23:0] LOCK_CYCLES = 24'd12_000_000
) (
  input logic             clk,
  input logic             rstn,
  pin_entry_ctrl_if.slave bus
);

  localparam int unsigned DW = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 2;
  localparam int unsigned TW = 24;
  localparam int unsigned BW = 16;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] MAX_FAIL_C = CW'(MAX_FAIL);
  // only the top NUM_DIGITS nibbles of the code take part in the compare
  localparam logic [BW-1:0] PIN_MASK   = BW'(16'hFFFF << (4 * (4 - NUM_DIGITS)));

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_FAIL,
    S_LOCKOUT,
    S_OPEN
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [IW-1:0]   digit_idx_q, digit_idx_d;
  logic [CW-1:0]   fail_count_q, fail_count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   enc_base_q, enc_base_d;
  logic [DW-1:0]   display_value_q, display_value_d;
  logic [IW-1:0]   display_select_q, display_select_d;
  logic            unlocked_q, unlocked_d;
  logic            locked_out_q, locked_out_d;
  logic            err_q, err_d;

  logic [DW-1:0]   cur_digit;
  logic            press_short, press_long, press_double;

  assign cur_digit    = bus.enc - enc_base_q;
  assign press_short  = (bus.pb_press_type == 3'd1);
  assign press_long   = (bus.pb_press_type == 3'd2);
  assign press_double = (bus.pb_press_type == 3'd3);

  // next-state, datapath and registered-output values
  always_comb begin
    state_d          = state_q;
    buf_d            = buf_q;
    digit_idx_d      = digit_idx_q;
    fail_count_d     = fail_count_q;
    timer_d          = timer_q;
    enc_base_d       = enc_base_q;
    display_value_d  = '0;
    display_select_d = '0;
    unlocked_d       = 1'b0;
    locked_out_d     = 1'b0;
    err_d            = 1'b0;

    case (state_q)
      S_ENTRY: begin
        if (press_short) begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (IW'(i) == digit_idx_q) buf_d[4*(3-i) +: 4] = cur_digit;
          end
          enc_base_d = bus.enc;
          if (digit_idx_q == LAST_IDX) state_d = S_CHECK;
          else                         digit_idx_d = digit_idx_q + 2'd1;
        end else if (press_long) begin
          buf_d       = '0;
          digit_idx_d = '0;
          enc_base_d  = bus.enc;
        end else if (press_double) begin
          if (digit_idx_q != '0) digit_idx_d = digit_idx_q - 2'd1;
          enc_base_d = bus.enc;
        end
      end

      S_CHECK: begin
        if (((buf_q ^ PIN_CODE) & PIN_MASK) == '0) begin
          fail_count_d = '0;
          state_d      = S_OPEN;
        end else if (({1'b0, fail_count_q} + 3'd1) == 3'(MAX_FAIL)) begin
          fail_count_d = MAX_FAIL_C;
          timer_d      = LOCK_CYCLES - 24'd1;
          state_d      = S_LOCKOUT;
        end else begin
          fail_count_d = fail_count_q + 2'd1;
          timer_d      = FAIL_HOLD - 24'd1;
          state_d      = S_FAIL;
        end
      end

      S_FAIL, S_LOCKOUT: begin
        if (timer_q == '0) begin
          buf_d       = '0;
          digit_idx_d = '0;
          enc_base_d  = bus.enc;
          state_d     = S_ENTRY;
          if (state_q == S_LOCKOUT) fail_count_d = '0;
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end

      S_OPEN: begin
        if (press_long) begin
          buf_d       = '0;
          digit_idx_d = '0;
          enc_base_d  = bus.enc;
          state_d     = S_ENTRY;
        end
      end

      default: state_d = S_ENTRY;
    endcase

    // outputs follow the state being entered so status flips with the transition
    case (state_d)
      S_ENTRY: begin
        display_value_d  = bus.enc - enc_base_d;
        display_select_d = digit_idx_d;
      end
      S_FAIL: begin
        display_value_d = 4'hE;
        err_d           = 1'b1;
      end
      S_LOCKOUT: begin
        display_value_d = 4'hF;
        locked_out_d    = 1'b1;
      end
      S_OPEN:  unlocked_d = 1'b1;
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= S_ENTRY;
      buf_q            <= '0;
      digit_idx_q      <= '0;
      fail_count_q     <= '0;
      timer_q          <= '0;
      enc_base_q       <= bus.enc;
      display_value_q  <= '0;
      display_select_q <= '0;
      unlocked_q       <= 1'b0;
      locked_out_q     <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      buf_q            <= buf_d;
      digit_idx_q      <= digit_idx_d;
      fail_count_q     <= fail_count_d;
      timer_q          <= timer_d;
      enc_base_q       <= enc_base_d;
      display_value_q  <= display_value_d;
      display_select_q <= display_select_d;
      unlocked_q       <= unlocked_d;
      locked_out_q     <= locked_out_d;
      err_q            <= err_d;
    end
  end

  assign bus.display_value  = display_value_q;
  assign bus.display_select = display_select_q;
  assign bus.digit_idx      = digit_idx_q;
  assign bus.unlocked       = unlocked_q;
  assign bus.locked_out     = locked_out_q;
  assign bus.err            = err_q;
  assign bus.fail_count     = fail_count_q;

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
Sequencing controller between the rotary-encoder front end and the seven-segment driver for the unlock flow. It turns the encoder count and pushbutton press events into a NUM_DIGITS-digit hex PIN entry and compares the result against a stored code. It drives the display value and digit select, and reports unlock, failure and lockout status. It sits in the top level, fed by enc/pb_press_type and feeding seven_seg display_value/display_select.

Parameters:
NUM_DIGITS, 4, PIN length in hex digits (2..4)
PIN_CODE, 16'hC5A7, expected code; digit 0 in bits [15:12], lower digits follow
MAX_FAIL, 3, consecutive failures before lockout (1..3)
FAIL_HOLD, 24'd6_000_000, cycles the error indication is held
LOCK_CYCLES, 24'd12_000_000, lockout duration in cycles

Ports:
clk  input  1  system clock; single clock domain
rstn  input  1  synchronous active-low reset, sampled on rising clk
enc  input  4  encoder counter, free-running and wrapping mod 16
pb_press_type  input  3  one-cycle press event: 0 none, 1 short, 2 long, 3 double; 4..7 treated as none
display_value  output  4  hex nibble to seven_seg
display_select  output  2  digit position to seven_seg
digit_idx  output  2  index of the digit currently being edited
unlocked  output  1  high while in OPEN
locked_out  output  1  high while in LOCKOUT
err  output  1  high while in FAIL
fail_count  output  2  consecutive failed attempts

Behaviour:
- Clock, reset and events:
  - All state updates on rising clk.
  - rstn=0 forces: state=ENTRY, buffer cleared, digit_idx=0, fail_count=0, timer=0, enc_base<=enc, display_value=0, display_select=0, unlocked=0, locked_out=0, err=0.
  - Reset mid-operation aborts any hold or lockout.
- Digit selection: cur_digit = (enc - enc_base) mod 16, computed with 4-bit wrap. enc_base is re-captured from enc on every digit commit, backspace, clear and ENTRY re-entry, so each new digit starts at 0.
- ENTRY state (registered outputs, 1-cycle latency):
  - display_value=cur_digit; display_select=digit_idx.
  - short: buffer[digit_idx]<=cur_digit. If digit_idx==NUM_DIGITS-1, go to CHECK; otherwise digit_idx++.
  - long: clear buffer, digit_idx=0.
  - double: if digit_idx>0, digit_idx--; at 0 no change. enc_base re-captured in both cases.
- CHECK state (exactly 1 cycle, presses ignored):
  - Match: fail_count=0, go to OPEN.
  - Mismatch, fail_count+1==MAX_FAIL: fail_count saturates at MAX_FAIL, timer=LOCK_CYCLES-1, go to LOCKOUT.
  - Mismatch otherwise: fail_count++, timer=FAIL_HOLD-1, go to FAIL.
- FAIL state:
  - err=1; display_value=4'hE; display_select=0.
  - Timer decrements each cycle; presses ignored.
  - At timer==0: clear buffer, digit_idx=0, go to ENTRY.
- LOCKOUT state:
  - locked_out=1; display_value=4'hF; display_select=0.
  - Presses and encoder motion ignored.
  - At timer==0: fail_count=0, clear buffer, digit_idx=0, go to ENTRY.
- OPEN state:
  - unlocked=1; display_value=4'h0; display_select=0.
  - long: relock. Clear buffer, digit_idx=0, go to ENTRY.
  - short/double ignored.
- Status outputs are registered and change on the cycle of the state transition.
- Events arriving in the same cycle as a state change belong to the old state; they are never queued.
- The buffer is never compared while entry is partial.

Test Plan:
1. Bench parameters for all scenarios: FAIL_HOLD=4, LOCK_CYCLES=8, MAX_FAIL=3. Reset with enc=5 -> all outputs 0, state ENTRY; advance enc to 7 -> display_value=2 one cycle later.
2. Correct entry of C,5,A,7:
   - Rotate enc to each digit; short press per digit.
   - digit_idx steps 0,1,2,3.
   - 1 cycle after the 4th short, CHECK; 1 cycle later unlocked=1, fail_count=0.
   - Long press -> unlocked=0, back in ENTRY, digit_idx=0.
3. Wrong code 0000:
   - err=1 for exactly 4 cycles; fail_count=1.
   - Return to ENTRY with display_value=0.
   - Short presses during FAIL have no effect.
4. Three consecutive wrong codes:
   - Third CHECK -> locked_out=1, fail_count=3, display_value=F.
   - Held 8 cycles, then ENTRY with fail_count=0.
   - Long and short presses during lockout ignored.
5. Editing:
   - Enter C,5, then double press -> digit_idx=1.
   - Double at digit_idx=0 -> stays 0.
   - Long press mid-entry -> digit_idx=0, buffer cleared.
   - Encoder wrap enc_base=14, enc=2 -> display_value=4.
6. Reset edge cases:
   - rstn low during LOCKOUT cycle 3 -> next cycle locked_out=0, fail_count=0, ENTRY.
   - pb_press_type=5 -> no effect.
